atmospheric_light_controller: RTL
=================================

ATMOSPHERIC_LIGHT_CONTROLLER -- requirements
Module: atmospheric_light_controller

Interface
REQ-001 Parameter IMG_W, default 256, pixels per line of the dark-channel stream.
REQ-002 Parameter IMG_H, default 256, lines per frame.
REQ-003 Parameter A_MAX, default 240, clamp ceiling for atmospheric light; used only under REQ-025.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; begins a frame scan.
REQ-007 pix_valid  in  1  dark-channel sample present on min_all/rmin/gmin/bmin.
REQ-008 pix_ready  out  1  controller accepts a sample this cycle.
REQ-009 min_all  in  8  per-pixel dark-channel minimum.
REQ-010 rmin, gmin, bmin  in  8 each  per-channel minima of the same pixel.
REQ-011 Ar_global, Ag_global, Ab_global  out  8 each  frame atmospheric light, registered.
REQ-012 a_valid  out  1  Ar/Ag/Ab_global hold a completed frame result.
REQ-013 busy  out  1  scan in progress.
REQ-014 done  out  1  one-cycle pulse, frame result published.

Function
REQ-015 FSM states IDLE, SCAN, PUBLISH; IDLE->SCAN on start; SCAN->PUBLISH when the accepted-pixel count reaches IMG_W*IMG_H; PUBLISH->IDLE unconditionally after one cycle.
REQ-016 pix_ready = 1 exactly in SCAN; busy = 1 in SCAN and PUBLISH; a sample is accepted when pix_valid && pix_ready.
REQ-017 On IDLE->SCAN: running max cleared to 0, running Ar/Ag/Ab cleared to 0, pixel counter cleared to 0.
REQ-018 Per accepted sample: if min_all >= running max, running max <= min_all and running Ar/Ag/Ab <= rmin/gmin/bmin; otherwise hold (ties: later pixel wins; first pixel always captured).
REQ-019 Pixel counter width $clog2(IMG_W*IMG_H+1), increments only on acceptance; pix_valid low stalls without state change.
REQ-020 In PUBLISH: Ar/Ag/Ab_global <= running values, a_valid <= 1, done = 1; latency last accepted pixel -> done = 1 cycle.
REQ-021 Published outputs and a_valid hold between frames, including through a following SCAN, until the next PUBLISH.
REQ-022 start while busy is ignored; start coincident with rst is ignored.
REQ-023 No combinational path from any input to any output except pix_ready (state-decoded only, not input-dependent).

Reset
REQ-024 rst (any state, incl. mid-SCAN) forces IDLE next cycle; Ar/Ag/Ab_global = 0, a_valid = 0, done = 0, busy = 0, pix_ready = 0, running max/values and counter = 0; partial frame discarded.

Configuration
REQ-025 Macro ATMLIGHT_CLAMP_EN: defined -> in PUBLISH each published channel = min(running value, A_MAX); undefined -> running values published unmodified and A_MAX unused.

Structure
REQ-026 Shared package atm_light_pkg holds state enum (IDLE, SCAN, PUBLISH) and PIX_W = 8 constant.
REQ-027 One sub-module atm_light_max_tracker: registered compare-and-capture of REQ-017/REQ-018 with clear and enable inputs; controller holds FSM, counter, publish registers.

Verification (bench with IMG_W=4, IMG_H=4)
REQ-028 16 samples min_all=0..15, rmin=min_all+100, gmin=min_all+50, bmin=min_all -> done once, Ar/Ag/Ab_global=115/65/15, a_valid=1.
REQ-029 Tie: min_all=200 at pixels 3 (rmin=10) and 9 (rmin=20), others 5 -> Ar_global=20.
REQ-030 pix_valid toggled every other cycle over 16 samples -> done exactly 1 cycle after 16th acceptance, no early done.
REQ-031 rst after 7 accepted samples, then full frame of min_all=1, rmin=gmin=bmin=9 -> outputs 0 with a_valid=0 post-reset, then 9/9/9 after done.
REQ-032 start pulsed mid-SCAN -> ignored, counter unaffected, single done; previous frame result held until that done.
REQ-033 ATMLIGHT_CLAMP_EN defined, peak pixel rmin=gmin=bmin=255 -> Ar/Ag/Ab_global=240; undefined -> 255.

Source files
------------

// File: rtl/atm_light_pkg.sv
// Shared definitions for the atmospheric light controller: controller state
// encoding, pixel sample width and a saturating ceiling helper.
package atm_light_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PUBLISH = 2'd2
    } state_e;

    // Limit a sample to a ceiling value.
    function automatic logic [PIX_W-1:0] clamp_ceil(
        input logic [PIX_W-1:0] value,
        input logic [PIX_W-1:0] ceiling
    );
        logic [PIX_W-1:0] result;
        if (value > ceiling) begin
            result = ceiling;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/atm_light_max_tracker.sv
// Running dark-channel maximum tracker. On each enabled sample whose
// dark-channel value is at least the current maximum, the maximum and the
// pixel's per-channel minima are captured (ties go to the later pixel, and
// the first pixel after a clear is always captured since the max is 0).
module atm_light_max_tracker
    import atm_light_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [PIX_W-1:0] min_all,
    input  logic [PIX_W-1:0] rmin,
    input  logic [PIX_W-1:0] gmin,
    input  logic [PIX_W-1:0] bmin,
    output logic [PIX_W-1:0] run_max,
    output logic [PIX_W-1:0] run_r,
    output logic [PIX_W-1:0] run_g,
    output logic [PIX_W-1:0] run_b
);

    logic [PIX_W-1:0] max_r;
    logic [PIX_W-1:0] ar_r;
    logic [PIX_W-1:0] ag_r;
    logic [PIX_W-1:0] ab_r;

    // Compare-and-capture of the brightest dark-channel pixel seen so far.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_r <= {PIX_W{1'b0}};
            ar_r  <= {PIX_W{1'b0}};
            ag_r  <= {PIX_W{1'b0}};
            ab_r  <= {PIX_W{1'b0}};
        end else if (clear) begin
            max_r <= {PIX_W{1'b0}};
            ar_r  <= {PIX_W{1'b0}};
            ag_r  <= {PIX_W{1'b0}};
            ab_r  <= {PIX_W{1'b0}};
        end else if (en && (min_all >= max_r)) begin
            max_r <= min_all;
            ar_r  <= rmin;
            ag_r  <= gmin;
            ab_r  <= bmin;
        end else begin
            max_r <= max_r;
            ar_r  <= ar_r;
            ag_r  <= ag_r;
            ab_r  <= ab_r;
        end
    end

    assign run_max = max_r;
    assign run_r   = ar_r;
    assign run_g   = ag_r;
    assign run_b   = ab_r;

endmodule

// File: rtl/atmospheric_light_controller.sv
// Frame-level atmospheric light estimator. Scans IMG_W*IMG_H dark-channel
// samples, tracks the pixel with the largest dark-channel value and
// publishes its per-channel minima as the frame's atmospheric light.
// Optional build macro ATMLIGHT_CLAMP_EN: when defined, each published
// channel is limited to A_MAX; when undefined, values pass unmodified.
module atmospheric_light_controller
    import atm_light_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int A_MAX = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] min_all,
    input  logic [PIX_W-1:0] rmin,
    input  logic [PIX_W-1:0] gmin,
    input  logic [PIX_W-1:0] bmin,
    output logic [PIX_W-1:0] Ar_global,
    output logic [PIX_W-1:0] Ag_global,
    output logic [PIX_W-1:0] Ab_global,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int PIX_TOTAL = IMG_W * IMG_H;
    localparam int CNT_W     = $clog2(PIX_TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_TOTAL - 1);

`ifdef ATMLIGHT_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    // Without clamping the ceiling is full scale, which makes the limit an identity.
    localparam logic [PIX_W-1:0] PUB_CEIL = CLAMP_ON ? PIX_W'(A_MAX) : {PIX_W{1'b1}};

    state_e           state_r;
    state_e           state_s;
    logic             start_scan_s;
    logic             accept_s;
    logic [CNT_W-1:0] cnt_r;
    logic             pix_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             a_valid_r;
    logic [PIX_W-1:0] ar_global_r;
    logic [PIX_W-1:0] ag_global_r;
    logic [PIX_W-1:0] ab_global_r;
    logic [PIX_W-1:0] run_max_s;
    logic [PIX_W-1:0] run_r_s;
    logic [PIX_W-1:0] run_g_s;
    logic [PIX_W-1:0] run_b_s;

    // pix_ready is a registered state decode, so acceptance never depends
    // combinationally on an output derived from inputs.
    assign accept_s = pix_valid && pix_ready_r;

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        state_s      = state_r;
        start_scan_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s      = SCAN;
                    start_scan_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (accept_s && (cnt_r == LAST_IDX)) begin
                    state_s = PUBLISH;
                end else begin
                    state_s = SCAN;
                end
            end
            PUBLISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pix_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            pix_ready_r <= (state_s == SCAN);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == PUBLISH);
        end
    end

    // Accepted-pixel counter, cleared when a scan begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (start_scan_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    atm_light_max_tracker u_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_scan_s),
        .en      (accept_s),
        .min_all (min_all),
        .rmin    (rmin),
        .gmin    (gmin),
        .bmin    (bmin),
        .run_max (run_max_s),
        .run_r   (run_r_s),
        .run_g   (run_g_s),
        .run_b   (run_b_s)
    );

    // Publish registers: loaded once per frame, held through later scans.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_global_r <= {PIX_W{1'b0}};
            ag_global_r <= {PIX_W{1'b0}};
            ab_global_r <= {PIX_W{1'b0}};
            a_valid_r   <= 1'b0;
        end else if (state_r == PUBLISH) begin
            ar_global_r <= clamp_ceil(run_r_s, PUB_CEIL);
            ag_global_r <= clamp_ceil(run_g_s, PUB_CEIL);
            ab_global_r <= clamp_ceil(run_b_s, PUB_CEIL);
            a_valid_r   <= 1'b1;
        end else begin
            ar_global_r <= ar_global_r;
            ag_global_r <= ag_global_r;
            ab_global_r <= ab_global_r;
            a_valid_r   <= a_valid_r;
        end
    end

    assign pix_ready = pix_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign a_valid   = a_valid_r;
    assign Ar_global = ar_global_r;
    assign Ag_global = ag_global_r;
    assign Ab_global = ab_global_r;

endmodule
